// File: rtl/ingress_drr_arbiter.sv
// rtl/ingress_drr_arbiter.sv - deficit-round-robin grant scheduler for four ingress pointer FIFOs
// Signed byte credit per port, per-port quantum refill, grant held until the datapath reports done.
module ingress_drr_arbiter #(
  parameter int QUANTUM_W = 14,
  parameter int LEN_W     = 13,
  parameter int CREDIT_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [3:0]             i_req_empty,
  input  logic                   i_bp,
  input  logic [4*QUANTUM_W-1:0] i_cfg_quantum,
  input  logic                   i_done,
  input  logic [LEN_W-1:0]       i_done_len,
  output logic                   o_grant_valid,
  output logic [1:0]             o_grant_sel,
  output logic [3:0]             o_grant_onehot,
  output logic                   o_proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_BUSY} state_t;

  localparam logic signed [CREDIT_W-1:0] ZERO = '0;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [1:0]                 r_rr_ptr;
  logic signed [CREDIT_W-1:0] r_credit [4];
  logic                       r_grant_valid;
  logic [1:0]                 r_grant_sel;
  logic [3:0]                 r_grant_onehot;
  logic                       r_proto_err;

  logic [3:0]                 w_eligible;
  logic signed [CREDIT_W-1:0] w_quantum [4];
  logic signed [CREDIT_W-1:0] w_len;
  logic signed [CREDIT_W-1:0] w_post_charge;
  logic                       w_found;
  logic [1:0]                 w_pick;
  logic [1:0]                 w_idx;
  logic                       w_grant;
  logic                       w_charge;

  assign o_grant_valid  = r_grant_valid;
  assign o_grant_sel    = r_grant_sel;
  assign o_grant_onehot = r_grant_onehot;
  assign o_proto_err    = r_proto_err;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_quantum[i]  = CREDIT_W'(i_cfg_quantum[i*QUANTUM_W +: QUANTUM_W]);
      w_eligible[i] = !i_req_empty[i] && (r_credit[i] > ZERO);
    end
  end

  assign w_len         = CREDIT_W'(i_done_len);
  assign w_charge      = (r_state == S_BUSY) && i_done;
  assign w_post_charge = r_credit[r_grant_sel] - w_len;

  // Scan downwards so the last hit is the first eligible port in rotation order from rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_rr_ptr + 2'(k);
      if (w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_bp) begin
          if (w_found) begin
            w_next_state = S_BUSY;
            w_grant      = 1'b1;
          end else if (i_req_empty != 4'hF) begin
            w_next_state = S_REFILL;
          end
        end
      end
      S_REFILL: w_next_state = S_IDLE;
      S_BUSY:   if (i_done) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= 2'd0;
      r_grant_valid  <= 1'b0;
      r_grant_sel    <= 2'd0;
      r_grant_onehot <= 4'd0;
      r_proto_err    <= 1'b0;
      for (int i = 0; i < 4; i++) r_credit[i] <= ZERO;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_grant_valid  <= 1'b1;
        r_grant_sel    <= w_pick;
        r_grant_onehot <= 4'b0001 << w_pick;
      end else if (w_charge) begin
        r_grant_valid  <= 1'b0;
        r_grant_onehot <= 4'd0;
        r_rr_ptr       <= (w_post_charge > ZERO && !i_req_empty[r_grant_sel]) ?
                          r_grant_sel : r_grant_sel + 2'd1;
      end
      if (i_done && r_state != S_BUSY) r_proto_err <= 1'b1;
      // The granted port keeps its credit while busy even if its FIFO drains mid-frame.
      for (int i = 0; i < 4; i++) begin
        if (w_charge && 2'(i) == r_grant_sel) begin
          r_credit[i] <= w_post_charge;
        end else if (r_state == S_REFILL && !i_req_empty[i]) begin
          r_credit[i] <= r_credit[i] + w_quantum[i];
        end else if (i_req_empty[i] && r_credit[i] > ZERO &&
                     !(r_state == S_BUSY && 2'(i) == r_grant_sel)) begin
          r_credit[i] <= ZERO;
        end
      end
    end
  end

endmodule

// File: tb/tb_ingress_drr_arbiter.sv
// tb/tb_ingress_drr_arbiter.sv - self-checking bench for ingress_drr_arbiter
// Integer-credit DRR model checked every cycle, plus directed scenarios with literal expectations.
module tb_ingress_drr_arbiter;
  localparam int QW = 14;
  localparam int LW = 13;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_empty = 4'hF;
  logic          bp = 1'b0;
  logic          done = 1'b0;
  logic [LW-1:0] done_len = '0;
  int            tb_q [4];
  logic [4*QW-1:0] cfg_quantum;

  logic          grant_valid;
  logic [1:0]    grant_sel;
  logic [3:0]    grant_onehot;
  logic          proto_err;

  assign cfg_quantum = {QW'(tb_q[3]), QW'(tb_q[2]), QW'(tb_q[1]), QW'(tb_q[0])};

  ingress_drr_arbiter #(.QUANTUM_W(QW), .LEN_W(LW), .CREDIT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_empty(req_empty), .i_bp(bp),
    .i_cfg_quantum(cfg_quantum), .i_done(done), .i_done_len(done_len),
    .o_grant_valid(grant_valid), .o_grant_sel(grant_sel),
    .o_grant_onehot(grant_onehot), .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting to pick, 1 = refilling, 2 = serving a frame.
  int   m_credit [4];
  int   m_nc [4];
  int   m_rr, m_phase, m_sel, m_bsel, m_pick;
  logic m_valid, m_perr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_credit = '{0, 0, 0, 0};
      m_rr = 0; m_phase = 0; m_sel = 0; m_valid = 1'b0; m_perr = 1'b0;
    end else begin
      m_nc   = m_credit;
      m_bsel = (m_phase == 2) ? m_sel : -1;
      if (m_phase == 2) begin
        if (done) begin
          m_nc[m_sel] = m_nc[m_sel] - int'(done_len);
          m_valid = 1'b0;
          m_phase = 0;
          m_rr = (m_nc[m_sel] > 0 && !req_empty[m_sel]) ? m_sel : (m_sel + 1) % 4;
        end
      end else begin
        if (done) m_perr = 1'b1;
        if (m_phase == 1) begin
          for (int i = 0; i < 4; i++) if (!req_empty[i]) m_nc[i] = m_nc[i] + tb_q[i];
          m_phase = 0;
        end else if (!bp) begin
          m_pick = -1;
          for (int k = 0; k < 4; k++)
            if (m_pick < 0 && !req_empty[(m_rr + k) % 4] && m_credit[(m_rr + k) % 4] > 0)
              m_pick = (m_rr + k) % 4;
          if (m_pick >= 0) begin
            m_valid = 1'b1; m_sel = m_pick; m_phase = 2;
          end else if (req_empty != 4'hF) begin
            m_phase = 1;
          end
        end
      end
      for (int i = 0; i < 4; i++)
        if (req_empty[i] && i != m_bsel && m_credit[i] > 0) m_nc[i] = 0;
      m_credit = m_nc;
    end
  end

  always @(negedge clk) begin
    check("cyc_valid", grant_valid, m_valid);
    check("cyc_onehot", grant_onehot, m_valid ? (1 << m_sel) : 0);
    if (m_valid) check("cyc_sel", grant_sel, m_sel);
    check("cyc_proto_err", proto_err, m_perr);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!grant_valid && n < budget);
    check("grant_wait", grant_valid, 1);
  endtask

  task automatic serve(input int len);
    done = 1'b1;
    done_len = LW'(len);
    tick();
    done = 1'b0;
    check("drop_after_done", grant_valid, 0);
  endtask

  int n;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_q = '{0, 0, 0, 0};
    #3;
    check("rst_valid", grant_valid, 0);
    check("rst_onehot", grant_onehot, 0);
    check("rst_sel", grant_sel, 0);
    check("rst_perr", proto_err, 0);
    tick();
    rst = 1'b0;

    // Port 2 alone: refill then grant three cycles after the request.
    tb_q[2] = 1536;
    req_empty = 4'b1011;
    wait_grant(8, n);
    check("p2_latency", n, 3);
    check("p2_onehot", grant_onehot, 4'b0100);
    serve(64);
    check("p2_credit_1472", m_credit[2], 1472);
    wait_grant(8, n);
    check("p2_regrant_latency", n, 1);
    check("p2_regrant_sel", grant_sel, 2);
    serve(64);
    req_empty = 4'hF;
    tick();
    check("p2_empty_reset", m_credit[2], 0);

    // Equal quanta: four frames per port per round.
    tb_q[0] = 256;
    tb_q[1] = 256;
    req_empty = 4'b1100;
    for (int i = 0; i < 16; i++) begin
      wait_grant(8, n);
      check($sformatf("eq_seq_%0d", i), grant_sel, ((i % 8) < 4) ? 0 : 1);
      serve(64);
    end

    // 512/256 quanta: eight frames to port 0 per four to port 1.
    tb_q[0] = 512;
    for (int i = 0; i < 24; i++) begin
      wait_grant(8, n);
      check($sformatf("wt_seq_%0d", i), grant_sel, ((i % 12) < 8) ? 0 : 1);
      serve(64);
    end

    // Backpressure blocks new grants but never a grant in progress.
    bp = 1'b1;
    req_empty = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_idle_nogrant", grant_valid, 0);
    end
    bp = 1'b0;
    wait_grant(8, n);
    check("bp_release_latency", n, 3);
    check("bp_release_sel", grant_sel, 0);
    bp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_busy_hold", grant_valid, 1);
      check("bp_busy_sel", grant_sel, 0);
    end
    serve(64);
    bp = 1'b0;
    check("p0_credit_448", m_credit[0], 448);

    // Positive credit is zeroed when the port drains.
    tb_q[3] = 1000;
    req_empty = 4'b0111;
    wait_grant(8, n);
    check("p3_sel", grant_sel, 3);
    serve(0);
    check("p3_credit_1000", m_credit[3], 1000);
    req_empty = 4'hF;
    tick();
    check("p3_credit_zeroed", m_credit[3], 0);
    tb_q[3] = 0;
    req_empty = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("p3_no_grant_q0", grant_valid, 0);
    end
    req_empty = 4'hF;
    tick();
    tick();

    // Debt survives an empty FIFO and must be repaid by refills.
    req_empty = 4'b1101;
    wait_grant(8, n);
    check("p1_sel", grant_sel, 1);
    serve(556);
    check("p1_debt", m_credit[1], -300);
    req_empty = 4'hF;
    tick();
    tick();
    check("p1_debt_kept", m_credit[1], -300);
    req_empty = 4'b1101;
    tick();
    tick();
    check("p1_after_refill", m_credit[1], -44);
    check("p1_no_grant_debt", grant_valid, 0);
    wait_grant(8, n);
    check("p1_second_refill_latency", n, 3);
    check("p1_grant_sel", grant_sel, 1);
    serve(64);

    // done while idle: sticky error, no effect on credit or rotation.
    req_empty = 4'hF;
    tick();
    tick();
    done = 1'b1;
    done_len = LW'(100);
    tick();
    done = 1'b0;
    check("perr_set", proto_err, 1);
    tick();
    tick();
    tick();
    check("perr_sticky", proto_err, 1);
    check("perr_credit0", m_credit[0], 0);
    check("perr_credit1", m_credit[1], 0);
    req_empty = 4'b1100;
    wait_grant(8, n);
    check("perr_rr_kept_sel", grant_sel, 1);

    // Asynchronous reset in the middle of a grant.
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", grant_valid, 0);
    check("arst_onehot", grant_onehot, 0);
    check("arst_sel", grant_sel, 0);
    check("arst_perr", proto_err, 0);
    tick();
    rst = 1'b0;
    req_empty = 4'hF;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
